// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit.
//   bpu_state_t : table sweep FSM states (INIT sweeps the tables, RUN predicts and trains)
//   CNT_WEAK_NT : weakly not-taken counter value written by the sweep
//   btb_entry_t : one BTB line {valid, tag, target}. The tag field is 32 bits wide so
//                 any TAG_W fits. Unused upper bits are always written as zero.
//   sat_update  : saturating up/down counter step
package bpu_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_t;

  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // Counters up to 8 bits wide. The caller casts to its own CNT_W.
  function automatic logic [7:0] sat_update(input logic [7:0] cnt,
                                            input logic       taken,
                                            input logic [7:0] cnt_max);
    logic [7:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != cnt_max) res = cnt + 8'd1;
    end else begin
      if (cnt != 8'd0) res = cnt - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: 2**IDX_W saturating counters.
//   clk        : clock
//   rd_idx     : combinational read index (F-stage lookup)
//   rd_cnt     : counter at rd_idx. It shows the contents from before any write at this edge.
//   upd_en     : train the counter at upd_idx toward upd_taken
//   upd_idx    : training index
//   upd_taken  : resolved direction
//   sweep_en   : initialisation write. It takes priority over training.
//   sweep_idx  : entry being initialised to weakly not-taken
module bpu_pht
  import bpu_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             sweep_en,
  input  logic [IDX_W-1:0] sweep_idx
);

  // Weakly not-taken for any width: MSB clear, all lower bits set (01 for CNT_W=2).
  localparam logic [CNT_W-1:0] WEAK_NT = {CNT_WEAK_NT[1], {(CNT_W-1){CNT_WEAK_NT[0]}}};
  localparam logic [7:0]       CNT_MAX = 8'({CNT_W{1'b1}});

  // No reset on the array itself: the INIT sweep gives every entry a defined value.
  logic [CNT_W-1:0] cnt_mem [2**IDX_W];

  assign rd_cnt = cnt_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      cnt_mem[sweep_idx] <= WEAK_NT;
    end else if (upd_en) begin
      cnt_mem[upd_idx] <= CNT_W'(sat_update(8'(cnt_mem[upd_idx]), upd_taken, CNT_MAX));
    end
  end

endmodule

// File: rtl/bpu_btb_predictor.sv
// Branch prediction unit for the 5-stage MIPS pipeline: 2-bit PHT plus direct-mapped BTB.
// Optional gshare indexing is enabled by defining BPU_GSHARE_EN.
//   clk, rst          : clock, asynchronous active-high reset
//   stallF            : fetch stalled. It blocks the speculative history shift.
//   pcF               : fetch PC
//   pred_hitF         : BTB valid and tag match
//   pred_takenF       : hit and counter MSB
//   pred_targetF      : BTB target, or 0 on a miss
//   pred_ghrF         : history used for this lookup (0 without gshare)
//   upd_*M            : resolved branch in M: valid, pc, direction, target,
//                       predicted direction/target, carried history
//   mispredM          : misprediction (combinational)
//   redirect_pcM      : correct next PC
//   flushD/E/M        : flush requests, each equal to mispredM
//   init_done         : high once the table sweep has finished
//   fsm_state         : sweep FSM state, exposed for observation
// Table access rules:
//   After reset the tables are swept, one entry per cycle, for 2**IDX_W cycles.
//   In that window every prediction output is 0 and updates are dropped.
//   A lookup and an update to the same index in the same cycle: the lookup sees the old
//   contents, and the new contents are visible the next cycle.
module bpu_btb_predictor
  import bpu_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int TAG_W = 12,
  parameter int CNT_W = 2,
  parameter int GHR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic [31:0]      pcF,
  output logic             pred_hitF,
  output logic             pred_takenF,
  output logic [31:0]      pred_targetF,
  output logic [GHR_W-1:0] pred_ghrF,
  input  logic             upd_validM,
  input  logic [31:0]      upd_pcM,
  input  logic             upd_takenM,
  input  logic [31:0]      upd_targetM,
  input  logic             upd_pred_takenM,
  input  logic [31:0]      upd_pred_targetM,
  input  logic [GHR_W-1:0] upd_ghrM,
  output logic             mispredM,
  output logic [31:0]      redirect_pcM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             init_done,
  output bpu_state_t       fsm_state
);

  localparam int              ENTRIES  = 2**IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  bpu_state_t       state, state_next;
  logic [IDX_W-1:0] sweep_idx;
  logic             run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweep_idx <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) sweep_idx <= sweep_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep_idx == LAST_IDX) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  assign run       = (state == RUN);
  assign init_done = run;
  assign fsm_state = state;

  // Index and tag fields
  logic [IDX_W-1:0] f_idx, m_idx, f_pht_idx, m_pht_idx;
  logic [TAG_W-1:0] f_tag, m_tag;

  assign f_idx = pcF[IDX_W+1:2];
  assign m_idx = upd_pcM[IDX_W+1:2];
  assign f_tag = pcF[IDX_W+2 +: TAG_W];
  assign m_tag = upd_pcM[IDX_W+2 +: TAG_W];

  // Misprediction / redirect
  always_comb begin
    mispredM     = run & upd_validM &
                   ((upd_takenM != upd_pred_takenM) |
                    (upd_takenM & (upd_targetM != upd_pred_targetM)));
    redirect_pcM = '0;
    if (run) redirect_pcM = upd_takenM ? upd_targetM : upd_pcM + 32'd8;  // +8 skips the delay slot
  end

  assign flushD = mispredM;
  assign flushE = mispredM;
  assign flushM = mispredM;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign f_pht_idx = f_idx ^ IDX_W'(ghr);
  assign m_pht_idx = m_idx ^ IDX_W'(upd_ghrM);
  assign pred_ghrF = ghr;

  // The resolved history from M takes priority over the speculative F-stage shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (mispredM) begin
      ghr <= {upd_ghrM[GHR_W-2:0], upd_takenM};
    end else if (pred_hitF && !stallF) begin
      ghr <= {ghr[GHR_W-2:0], pred_takenF};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pcF[1:0], pcF[31:IDX_W+2+TAG_W]};
`else
  assign f_pht_idx = f_idx;
  assign m_pht_idx = m_idx;
  assign pred_ghrF = '0;

  logic unused_bits;
  assign unused_bits = ^{pcF[1:0], pcF[31:IDX_W+2+TAG_W], upd_ghrM, stallF};
`endif

  // PHT
  logic [CNT_W-1:0] pht_cnt;

  bpu_pht #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk       (clk),
    .rd_idx    (f_pht_idx),
    .rd_cnt    (pht_cnt),
    .upd_en    (run & upd_validM),
    .upd_idx   (m_pht_idx),
    .upd_taken (upd_takenM),
    .sweep_en  (~run),
    .sweep_idx (sweep_idx)
  );

  // BTB: the sweep clears only the valid bits. Tag and target are don't-care while valid is 0.
  btb_entry_t btb [ENTRIES];
  btb_entry_t btb_rd;
  logic       btb_hit;

  always_ff @(posedge clk) begin
    if (!run) begin
      btb[sweep_idx].valid <= 1'b0;
    end else if (upd_validM && upd_takenM) begin
      btb[m_idx] <= '{valid: 1'b1, tag: 32'(m_tag), target: upd_targetM};
    end
  end

  assign btb_rd  = btb[f_idx];
  assign btb_hit = btb_rd.valid & (btb_rd.tag == 32'(f_tag));

  assign pred_hitF    = run & btb_hit;
  assign pred_takenF  = pred_hitF & pht_cnt[CNT_W-1];
  assign pred_targetF = pred_hitF ? btb_rd.target : 32'd0;

endmodule
